pwm_button_conditioner: RTL and testbench

//  Upstream stage of the PWM duty-cycle controller. Converts two raw, bouncy, asynchronous push-button

---
 rtl/pwm_pkg.sv | 40 ++++
 rtl/btn_debounce_ch.sv | 174 +++++++++++++++++
 rtl/pwm_button_conditioner.sv | 100 ++++++++++
 tb/tb_pwm_button_conditioner.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM button conditioner.
//
// Contents:
//   - state encodings for the per-button debounce FSM (IDLE..RELEASE_CHK)
//   - typed FSM state enum built from those encodings
//   - default tick constants used as parameter defaults
//   - max3() helper for sizing the shared tick counter
package pwm_pkg;

  // Debounce FSM state encodings.
  localparam logic [2:0] IdleEnc       = 3'd0;
  localparam logic [2:0] PressChkEnc   = 3'd1;
  localparam logic [2:0] HeldEnc       = 3'd2;
  localparam logic [2:0] RepeatEnc     = 3'd3;
  localparam logic [2:0] ReleaseChkEnc = 3'd4;

  typedef enum logic [2:0] {
    StIdle       = IdleEnc,
    StPressChk   = PressChkEnc,
    StHeld       = HeldEnc,
    StRepeat     = RepeatEnc,
    StReleaseChk = ReleaseChkEnc
  } btn_state_e;

  // Default timing, in clk cycles (TickDiv) or debounce ticks (the rest).
  localparam int unsigned DefTickDiv          = 4;
  localparam int unsigned DefStableTicks      = 3;
  localparam int unsigned DefRepeatDelayTicks = 8;
  localparam int unsigned DefRepeatRateTicks  = 2;

  function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                       input int unsigned c);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return m;
  endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchronizer, debounce FSM and saturating tick counter.
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous reset, active-high
//   step_i     advance the FSM this cycle (debounce tick qualified by enable)
//   btn_raw_i  raw asynchronous button, active-high
//   level_o    debounced level (1 in HELD, REPEAT, RELEASE_CHK)
//   req_o      registered one-cycle request, high the cycle after an accepting tick
//
// Build option: PWM_BTN_AUTOREPEAT_EN adds the REPEAT state and hold-to-repeat requests.
module btn_debounce_ch
  import pwm_pkg::*;
#(
  parameter int unsigned STABLE_TICKS       = DefStableTicks,
  parameter int unsigned REPEAT_DELAY_TICKS = DefRepeatDelayTicks,
  parameter int unsigned REPEAT_RATE_TICKS  = DefRepeatRateTicks
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic step_i,
  input  logic btn_raw_i,
  output logic level_o,
  output logic req_o
);

`ifdef PWM_BTN_AUTOREPEAT_EN
  localparam int unsigned CntMax = max3(STABLE_TICKS, REPEAT_DELAY_TICKS, REPEAT_RATE_TICKS);
`else
  localparam int unsigned CntMax = STABLE_TICKS;
`endif
  localparam int unsigned CntW = $clog2(CntMax + 1);

  localparam logic [CntW-1:0] CntSat    = CntW'(CntMax);
  localparam logic [CntW-1:0] StableCnt = CntW'(STABLE_TICKS);
`ifdef PWM_BTN_AUTOREPEAT_EN
  localparam logic [CntW-1:0] DelayCnt  = CntW'(REPEAT_DELAY_TICKS);
  localparam logic [CntW-1:0] RateCnt   = CntW'(REPEAT_RATE_TICKS);
`endif

  if (STABLE_TICKS < 1) begin : g_bad_stable
    $error("STABLE_TICKS must be >= 1");
  end
  if (REPEAT_DELAY_TICKS < 1 || REPEAT_RATE_TICKS < 1) begin : g_bad_repeat
    $error("REPEAT_DELAY_TICKS and REPEAT_RATE_TICKS must be >= 1");
  end

  logic [1:0]      sync_q;
  logic            s;
  btn_state_e      state_q;
  logic [CntW-1:0] cnt_q;
  logic [CntW-1:0] cnt_inc;
  logic            level_q;
  logic            req_q;

  // Synchronizer runs regardless of step_i so the sample is always fresh.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[0], btn_raw_i};
    end
  end

  assign s       = sync_q[1];
  assign cnt_inc = (cnt_q == CntSat) ? cnt_q : cnt_q + 1'b1;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      level_q <= 1'b0;
      req_q   <= 1'b0;
    end else begin
      req_q <= 1'b0;
      if (step_i) begin
        unique case (state_q)
          StIdle: begin
            if (s) begin
              if (STABLE_TICKS == 1) begin
                state_q <= StHeld;
                cnt_q   <= '0;
                level_q <= 1'b1;
                req_q   <= 1'b1;
              end else begin
                state_q <= StPressChk;
                cnt_q   <= CntW'(1);
              end
            end
          end

          StPressChk: begin
            if (!s) begin
              state_q <= StIdle;
              cnt_q   <= '0;
            end else if (cnt_inc >= StableCnt) begin
              state_q <= StHeld;
              cnt_q   <= '0;
              level_q <= 1'b1;
              req_q   <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          StHeld: begin
            if (!s) begin
              if (STABLE_TICKS == 1) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
              end else begin
                state_q <= StReleaseChk;
                cnt_q   <= CntW'(1);
              end
`ifdef PWM_BTN_AUTOREPEAT_EN
            end else if (cnt_inc >= DelayCnt) begin
              state_q <= StRepeat;
              cnt_q   <= '0;
              req_q   <= 1'b1;
`endif
            end else begin
              cnt_q <= cnt_inc;
            end
          end

`ifdef PWM_BTN_AUTOREPEAT_EN
          StRepeat: begin
            if (!s) begin
              if (STABLE_TICKS == 1) begin
                state_q <= StIdle;
                cnt_q   <= '0;
                level_q <= 1'b0;
              end else begin
                state_q <= StReleaseChk;
                cnt_q   <= CntW'(1);
              end
            end else if (cnt_inc >= RateCnt) begin
              cnt_q <= '0;
              req_q <= 1'b1;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
`endif

          StReleaseChk: begin
            // A bounce back to 1 returns to HELD without a new request.
            if (s) begin
              state_q <= StHeld;
              cnt_q   <= '0;
            end else if (cnt_inc >= StableCnt) begin
              state_q <= StIdle;
              cnt_q   <= '0;
              level_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end

          default: begin
            state_q <= StIdle;
            cnt_q   <= '0;
            level_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level_o = level_q;
  assign req_o   = req_q;

endmodule

// File: rtl/pwm_button_conditioner.sv
// Button conditioner for the PWM duty-cycle controller: turns two raw bouncy buttons into
// clean one-cycle duty_inc / duty_dec step requests.
//
// Ports:
//   clk_i           system clock
//   rst_i           synchronous reset, active-high
//   ena_i           block enable; low freezes prescaler and FSMs and suppresses pulses
//   btn_inc_raw_i   raw increase button (asynchronous, active-high)
//   btn_dec_raw_i   raw decrease button (asynchronous, active-high)
//   duty_inc_o      one-cycle pulse: increase duty by one step
//   duty_dec_o      one-cycle pulse: decrease duty by one step
//   inc_level_o     debounced increase-button level
//   dec_level_o     debounced decrease-button level
//   tick_o          debounce sample strobe
//
// Build option: PWM_BTN_AUTOREPEAT_EN enables hold-to-repeat in both channels.
module pwm_button_conditioner
  import pwm_pkg::*;
#(
  parameter int unsigned TICK_DIV           = DefTickDiv,
  parameter int unsigned STABLE_TICKS       = DefStableTicks,
  parameter int unsigned REPEAT_DELAY_TICKS = DefRepeatDelayTicks,
  parameter int unsigned REPEAT_RATE_TICKS  = DefRepeatRateTicks
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic ena_i,
  input  logic btn_inc_raw_i,
  input  logic btn_dec_raw_i,
  output logic duty_inc_o,
  output logic duty_dec_o,
  output logic inc_level_o,
  output logic dec_level_o,
  output logic tick_o
);

  localparam int unsigned PresW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PresW-1:0] PresLast = PresW'(TICK_DIV - 1);

  if (TICK_DIV < 1) begin : g_bad_tick_div
    $error("TICK_DIV must be >= 1");
  end

  logic [PresW-1:0] presc_q;
  logic [PresW-1:0] presc_d;
  logic             tick;
  logic             inc_req;
  logic             dec_req;

  // Prescaler: 0..TICK_DIV-1, frozen while disabled.
  always_comb begin
    presc_d = presc_q;
    if (ena_i) begin
      presc_d = (presc_q == PresLast) ? '0 : presc_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  assign tick = ena_i && (presc_q == PresLast);

  btn_debounce_ch #(
    .STABLE_TICKS       (STABLE_TICKS),
    .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
  ) u_inc_ch (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .step_i    (tick),
    .btn_raw_i (btn_inc_raw_i),
    .level_o   (inc_level_o),
    .req_o     (inc_req)
  );

  btn_debounce_ch #(
    .STABLE_TICKS       (STABLE_TICKS),
    .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS),
    .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
  ) u_dec_ch (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .step_i    (tick),
    .btn_raw_i (btn_dec_raw_i),
    .level_o   (dec_level_o),
    .req_o     (dec_req)
  );

  // Requests are already registered in the channels; conflicting requests cancel each other
  // and a disabled block never pulses, even on the cycle right after a tick.
  assign duty_inc_o = ena_i & inc_req & ~dec_req;
  assign duty_dec_o = ena_i & dec_req & ~inc_req;
  assign tick_o     = tick;

endmodule

// File: tb/tb_pwm_button_conditioner.sv
// Scoreboard bench for pwm_button_conditioner (TICK_DIV=4, STABLE_TICKS=3, REPEAT 8/2).
// Stimulus pushes expected pulses (channel + cycle) into a queue; a negedge monitor pops and
// compares every pulse the DUT emits. Cycle n = state after the n-th rising clock edge.
module tb_pwm_button_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ena = 1'b1;
  logic bi  = 1'b0;
  logic bd  = 1'b0;
  logic duty_inc, duty_dec, inc_level, dec_level, tick;

  pwm_button_conditioner #(
    .TICK_DIV           (4),
    .STABLE_TICKS       (3),
    .REPEAT_DELAY_TICKS (8),
    .REPEAT_RATE_TICKS  (2)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst),
    .ena_i         (ena),
    .btn_inc_raw_i (bi),
    .btn_dec_raw_i (bd),
    .duty_inc_o    (duty_inc),
    .duty_dec_o    (duty_dec),
    .inc_level_o   (inc_level),
    .dec_level_o   (dec_level),
    .tick_o        (tick)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit is_inc;
    int at;
  } exp_t;

  exp_t expq[$];
  exp_t mon_e;

  // Monitor: every pulse must match the head of the expectation queue.
  always @(negedge clk) begin
    if (duty_inc || duty_dec) begin
      checks++;
      if (duty_inc && duty_dec) begin
        failures++;
        $display("FAIL pulse_excl: inc=1 dec=1 at cycle %0d, required at most one", cyc);
      end else if (expq.size() == 0) begin
        failures++;
        $display("FAIL pulse_unexpected: inc=%0b dec=%0b at cycle %0d, required none",
                 duty_inc, duty_dec, cyc);
      end else begin
        mon_e = expq.pop_front();
        if (mon_e.is_inc != duty_inc || mon_e.at != cyc) begin
          failures++;
          $display("FAIL pulse_match: got inc=%0b at cycle %0d, required inc=%0b at cycle %0d",
                   duty_inc, cyc, mon_e.is_inc, mon_e.at);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Return 1 time unit after rising edge n.
  task automatic wait_edge(input int n);
    while (cyc < n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Return at the falling edge of cycle n.
  task automatic at_neg(input int n);
    wait_edge(n);
    @(negedge clk);
  endtask

  task automatic do_reset(output int r);
    rst = 1'b1;
    wait_edge(cyc + 1);
    rst = 1'b0;
    r = cyc;
  endtask

  task automatic push(input bit is_inc, input int at);
    exp_t e;
    e.is_inc = is_inc;
    e.at     = at;
    expq.push_back(e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int r2;

    // 1: clean press, reset state, tick timing, level window.
    do_reset(r);
    bi = 1'b1;
    push(1'b1, r + 12);
    at_neg(r);
    chk("rst_duty_inc", duty_inc, 0);
    chk("rst_duty_dec", duty_dec, 0);
    chk("rst_inc_level", inc_level, 0);
    chk("rst_dec_level", dec_level, 0);
    chk("rst_tick", tick, 0);
    at_neg(r + 2);
    chk("tick_pre", tick, 0);
    at_neg(r + 3);
    chk("tick_first", tick, 1);
    at_neg(r + 11);
    chk("press_level_before", inc_level, 0);
    at_neg(r + 12);
    chk("press_level_at", inc_level, 1);
    wait_edge(r + 60);
    bi = 1'b0;
    at_neg(r + 71);
    chk("release_level_hold", inc_level, 1);
    at_neg(r + 72);
    chk("release_level_drop", inc_level, 0);

    // 2: bouncing decrease button never accepted.
    do_reset(r);
    for (int i = 0; i < 40; i++) begin
      wait_edge(r + i);
      bd = ((i / 3) % 2 == 0);
    end
    wait_edge(r + 40);
    bd = 1'b0;
    at_neg(r + 41);
    chk("bounce_level_mid", dec_level, 0);
    at_neg(r + 60);
    chk("bounce_level_end", dec_level, 0);

    // 3a: simultaneous press -> both levels up, no pulses.
    do_reset(r);
    bi = 1'b1;
    bd = 1'b1;
    at_neg(r + 13);
    chk("simul_inc_level", inc_level, 1);
    chk("simul_dec_level", dec_level, 1);
    wait_edge(r + 40);
    bi = 1'b0;
    bd = 1'b0;
    at_neg(r + 56);
    chk("simul_inc_idle", inc_level, 0);

    // 3b: inc 8 clks before dec -> inc pulse, then dec pulse.
    do_reset(r);
    bi = 1'b1;
    push(1'b1, r + 12);
    wait_edge(r + 8);
    bd = 1'b1;
    push(1'b0, r + 20);
    wait_edge(r + 30);
    bi = 1'b0;
    bd = 1'b0;
    at_neg(r + 50);
    chk("stagger_dec_idle", dec_level, 0);

    // 4: long hold (auto-repeat only with the build option).
    do_reset(r);
    bi = 1'b1;
    push(1'b1, r + 12);
`ifdef PWM_BTN_AUTOREPEAT_EN
    for (int k = 44; k <= 100; k += 8) push(1'b1, r + k);
`endif
    wait_edge(r + 100);
    bi = 1'b0;
    at_neg(r + 120);
    chk("hold_level_idle", inc_level, 0);

    // 5: reset while held -> outputs cleared, re-accepted 3 ticks later.
    do_reset(r);
    bi = 1'b1;
    push(1'b1, r + 12);
    wait_edge(r + 30);
    do_reset(r2);
    push(1'b1, r2 + 12);
    at_neg(r2);
    chk("midrst_duty_inc", duty_inc, 0);
    chk("midrst_inc_level", inc_level, 0);
    chk("midrst_tick", tick, 0);
    at_neg(r2 + 11);
    chk("midrst_level_before", inc_level, 0);
    at_neg(r2 + 12);
    chk("midrst_level_at", inc_level, 1);
    wait_edge(r2 + 20);
    bi = 1'b0;

    // 6: enable low during PRESS_CHK, prescaler frozen at its last count.
    wait_edge(r2 + 40);
    do_reset(r);
    bi = 1'b1;
    push(1'b1, r + 32);
    wait_edge(r + 7);
    ena = 1'b0;
    at_neg(r + 10);
    chk("ena_tick_gated", tick, 0);
    at_neg(r + 20);
    chk("ena_level_frozen", inc_level, 0);
    wait_edge(r + 27);
    ena = 1'b1;
    at_neg(r + 27);
    chk("ena_tick_resume", tick, 1);
    at_neg(r + 31);
    chk("ena_level_before", inc_level, 0);
    at_neg(r + 32);
    chk("ena_level_at", inc_level, 1);
    wait_edge(r + 40);
    bi = 1'b0;
    at_neg(r + 70);

    chk("pending_pulses", expq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
